// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding selects, sequencer states
// and the saturating increment used by the optional performance counters.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_EX  = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } hc_state_e;

  localparam int PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Priority comparator for one ID source operand: EX beats MEM beats WB,
// register 0 and unused sources always read the register file.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              used_i,
  input  logic              ex_valid_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output fwd_sel_e          sel_o
);

  logic rs_live;
  assign rs_live = used_i && (rs_i != '0);

  // A load in EX has no data yet; its consumer waits for the MEM forward.
  always_comb begin
    sel_o = FWD_RF;
    if (rs_live && ex_valid_i && ex_regwrite_i && !ex_memread_i && (ex_rd_i == rs_i))
      sel_o = FWD_EX;
    else if (rs_live && mem_regwrite_i && (mem_rd_i == rs_i))
      sel_o = FWD_MEM;
    else if (rs_live && wb_regwrite_i && (wb_rd_i == rs_i))
      sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: operand forwarding, load-use interlock, multi-cycle EX
// sequencer and memory-wait freeze. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      ex_valid,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic                      ex_mc,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      mem_regwrite,
  input  logic                      wb_regwrite,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      stall_mem,
  output logic                      bubble_ex,
  output logic                      bubble_wb,
  output logic                      mc_busy,
  output logic                      dbg_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]         perf_stall_cycles,
  output logic [PERF_W-1:0]         perf_bubbles
`endif
);

  localparam int CW         = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam int CNT_INIT_I = (MC_LAT > 1) ? MC_LAT - 2 : 0;
  localparam logic [CW-1:0] CNT_INIT = CW'(CNT_INIT_I);

  hc_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_wait, mc_start, mc_stall, lu_match, load_use;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_sel_e sel;
    fwd_select #(.REG_AW(REG_AW)) u_fwd (
      .rs_i           (id_rs[i*REG_AW +: REG_AW]),
      .used_i         (id_rs_used[i]),
      .ex_valid_i     (ex_valid),
      .ex_regwrite_i  (ex_regwrite),
      .ex_memread_i   (ex_memread),
      .ex_rd_i        (ex_rd),
      .mem_regwrite_i (mem_regwrite),
      .mem_rd_i       (mem_rd),
      .wb_regwrite_i  (wb_regwrite),
      .wb_rd_i        (wb_rd),
      .sel_o          (sel)
    );
    assign fwd_sel[i*2 +: 2] = sel;
  end

  always_comb begin
    lu_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd)) lu_match = 1'b1;
  end

  assign mem_wait = mem_req && !mem_ready;
  assign mc_start = (state_q == IDLE) && ex_valid && ex_mc && (MC_LAT > 1) && !mem_wait;
  // The final MC cycle (cnt==0) does not stall, so a load-use may bubble there.
  assign mc_stall = mc_start || ((state_q == MC_BUSY) && (cnt_q != '0));
  assign load_use = ex_valid && ex_memread && (ex_rd != '0) && lu_match &&
                    !mem_wait && !mc_stall;

  assign stall_if  = mem_wait || mc_stall || load_use;
  assign stall_id  = mem_wait || mc_stall || load_use;
  assign stall_ex  = mem_wait || mc_stall;
  assign stall_mem = mem_wait;
  assign bubble_ex = load_use;
  assign bubble_wb = mem_wait;
  assign mc_busy   = (state_q == MC_BUSY) || mc_start;
  assign dbg_state = (state_q == MC_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (!mem_wait) begin
      case (state_q)
        IDLE: begin
          if (mc_start) begin
            state_q <= MC_BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        MC_BUSY: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else             state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
    end else begin
      if (stall_if)  perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (bubble_ex) perf_bubbles      <= sat_inc(perf_bubbles);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (REG_AW=4, NUM_SRC=2, MC_LAT=3);
// perf counter checks are compiled in with HAZARD_PERF_EN.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] id_rs;
  logic [1:0] id_rs_used;
  logic       ex_valid, ex_regwrite, ex_memread, ex_mc;
  logic [3:0] ex_rd, mem_rd, wb_rd;
  logic       mem_regwrite, wb_regwrite, mem_req, mem_ready;
  logic [3:0] fwd_sel;
  logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, mc_busy;
  logic       dbg_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_bubbles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  hazard_ctrl_unit #(.REG_AW(4), .NUM_SRC(2), .MC_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_mc(ex_mc), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .mem_ready(mem_ready), .fwd_sel(fwd_sel),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
    .mc_busy(mc_busy), .dbg_state(dbg_state)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_bubbles(perf_bubbles)
`endif
  );

  // clock/reset
  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, mc_busy}
  function automatic logic [6:0] ctl();
    return {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, mc_busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rs_used = '0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_mc = 0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    mem_regwrite = 0; wb_regwrite = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Sample the control vector mid-cycle against the next queued expectation.
  task automatic cycle_check(input string tag);
    logic [6:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {25'd0, ctl()}, {25'd0, e});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("rst_ctl", {25'd0, ctl()}, 32'd0);
    check("rst_fwd", {28'd0, fwd_sel}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic mc_op();
    ex_valid = 1; ex_mc = 1; ex_regwrite = 1; ex_rd = 4'd7;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // forwarding priority on src0
    id_rs = {4'd0, 4'd3}; id_rs_used = 2'b01;
    ex_valid = 1; ex_regwrite = 1; ex_rd = 4'd3;
    mem_regwrite = 1; mem_rd = 4'd3; wb_regwrite = 1; wb_rd = 4'd3;
    #1 check("fwd_ex", {30'd0, fwd_sel[1:0]}, 32'b10);
    check("fwd_ex_ctl", {25'd0, ctl()}, 32'd0);
    ex_regwrite = 0;
    #1 check("fwd_mem", {30'd0, fwd_sel[1:0]}, 32'b01);
    mem_regwrite = 0;
    #1 check("fwd_wb", {30'd0, fwd_sel[1:0]}, 32'b11);
    id_rs = {4'd0, 4'd0}; ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
    ex_regwrite = 1; mem_regwrite = 1;
    #1 check("fwd_r0", {30'd0, fwd_sel[1:0]}, 32'b00);
    // src1 unused never forwards; src1 used with MEM and WB both matching picks MEM
    id_rs = {4'd9, 4'd0}; id_rs_used = 2'b01; mem_rd = 4'd9; wb_rd = 4'd9;
    ex_regwrite = 0; wb_regwrite = 1;
    #1 check("fwd_unused", {28'd0, fwd_sel}, 32'b0000);
    id_rs_used = 2'b10;
    #1 check("fwd_src1_mem", {28'd0, fwd_sel}, 32'b0100);
    clear_inputs();

    // load to r0 is not an interlock
    ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd0;
    id_rs = {4'd0, 4'd0}; id_rs_used = 2'b11;
    #1 check("lu_r0", {25'd0, ctl()}, 32'd0);

    // load-use on src1: one bubble, then MEM forward
    ex_rd = 4'd5; id_rs = {4'd5, 4'd1}; id_rs_used = 2'b10;
    #1 check("lu_fwd_ex_load", {30'd0, fwd_sel[3:2]}, 32'b00);
    exp_q.push_back(7'b1100100);
    cycle_check("lu_stall");
    ex_valid = 0; ex_memread = 0; ex_regwrite = 0; ex_rd = 4'd0;
    mem_regwrite = 1; mem_rd = 4'd5;
    #1 check("lu_next_fwd", {30'd0, fwd_sel[3:2]}, 32'b01);
    exp_q.push_back(7'b0000000);
    cycle_check("lu_next_ctl");
    clear_inputs();

    // MC op: 2 stall cycles then the final EX cycle
    mc_op();
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b0000001);
    cycle_check("mc_c1");
    cycle_check("mc_c2");
    cycle_check("mc_c3");
    clear_inputs();
    exp_q.push_back(7'b0000000);
    cycle_check("mc_done");
    check("mc_done_state", {31'd0, dbg_state}, 32'd0);

    // MC op with 2 memory-wait cycles mid-sequence: occupancy 5
    mc_op();
    exp_q.push_back(7'b1110001);
    cycle_check("mw_c1");
    mem_req = 1; mem_ready = 0;
    exp_q.push_back(7'b1111011);
    exp_q.push_back(7'b1111011);
    cycle_check("mw_c2");
    cycle_check("mw_c3");
    mem_req = 0;
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b0000001);
    cycle_check("mw_c4");
    cycle_check("mw_c5");
    clear_inputs();
    mem_req = 1; mem_ready = 1;
    exp_q.push_back(7'b0000000);
    cycle_check("mw_ready_nowait");
    clear_inputs();

    // memory wait suppresses a load-use bubble
    ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd6;
    id_rs = {4'd0, 4'd6}; id_rs_used = 2'b01; mem_req = 1;
    #1 check("mw_lu_suppress", {25'd0, ctl()}, 32'b1111010);
    clear_inputs();

    // MC final cycle coincident with a load-use: bubble applies there
    mc_op();
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b1110001);
    cycle_check("mclu_c1");
    cycle_check("mclu_c2");
    ex_memread = 1; id_rs = {4'd7, 4'd0}; id_rs_used = 2'b10;
    exp_q.push_back(7'b1100101);
    cycle_check("mclu_c3");
    clear_inputs();

    // reset in the middle of an MC sequence, then a full restart
    mc_op();
    exp_q.push_back(7'b1110001);
    cycle_check("mcrst_c1");
    #1 check("mcrst_busy", {25'd0, ctl()}, 32'b1110001);
    check("mcrst_state_busy", {31'd0, dbg_state}, 32'd1);
    do_reset();
    mc_op();
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b0000001);
    cycle_check("mcrst_r1");
    cycle_check("mcrst_r2");
    cycle_check("mcrst_r3");
    clear_inputs();
    @(posedge clk); #1;

`ifdef HAZARD_PERF_EN
    do_reset();
    check("perf_rst_stall", perf_stall_cycles, 32'd0);
    check("perf_rst_bub", perf_bubbles, 32'd0);
    ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd5;
    id_rs = {4'd5, 4'd0}; id_rs_used = 2'b10;
    exp_q.push_back(7'b1100100);
    cycle_check("perf_lu");
    clear_inputs();
    mc_op();
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b1110001);
    exp_q.push_back(7'b0000001);
    cycle_check("perf_mc1");
    cycle_check("perf_mc2");
    cycle_check("perf_mc3");
    clear_inputs();
    @(posedge clk); #1;
    check("perf_stall", perf_stall_cycles, 32'd3);
    check("perf_bub", perf_bubbles, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time exceeded 50000");
    $fatal(1, "timeout");
  end

endmodule
